// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the pushbutton conditioning block.
package key_pkg;

  // 20 ms at 50 MHz on the board; a short count keeps simulations quick.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES     = 8;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_N_KEYS          = 4;

  // Counter width able to hold 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the board pins and the debouncer.
// master = pin/stimulus side driving key_n; slave = the debouncer.
interface key_debounce_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] key_n;        // raw buttons, 0 = pressed
  logic [N_KEYS-1:0] key_level;    // debounced, 1 = pressed
  logic [N_KEYS-1:0] key_press;    // one-cycle strobe on accepted press
  logic [N_KEYS-1:0] key_release;  // one-cycle strobe on accepted release

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_channel.sv
// One pushbutton: synchronizer, stability counter, accepted-state flop and
// press/release strobes.
module key_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic Clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic                   stable_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   press_reg;
  logic                   release_reg;

  // Plain flop chain into the clock domain; reset value is "released".
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) sync_reg <= '1;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_n};
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Accept a new level only after it has differed from the accepted one for
  // DEBOUNCE_CYCLES consecutive edges; any return to the accepted level
  // restarts the count. The counter clears on acceptance, so it never wraps.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stable_reg  <= 1'b1;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      if (s == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg  <= s;
        cnt_reg     <= '0;
        press_reg   <= ~s;
        release_reg <= s;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Level comes straight off the accepted-state flop, so it changes on the
  // same edge as the strobe it accompanies.
  assign key_level   = ~stable_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS independent active-low pushbuttons into a clean level plus
// press/release strobes per key.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS          = DEFAULT_N_KEYS,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic           Clk,
  input  logic           reset,
  key_debounce_if.slave  keys
);

  // One fully independent channel per key.
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_channel (
        .Clk         (Clk),
        .reset       (reset),
        .key_n       (keys.key_n[gi]),
        .key_level   (keys.key_level[gi]),
        .key_press   (keys.key_press[gi]),
        .key_release (keys.key_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a strobe scoreboard.
module tb_key_debounce;
  import key_pkg::*;

  logic Clk = 1'b0;
  logic reset = 1'b0;

  key_debounce_if #(.N_KEYS(4)) kif();

  key_debounce #(
    .N_KEYS          (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
    .CNT_W           (cnt_width(SIM_DEBOUNCE_CYCLES))
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .keys  (kif)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } ev_t;

  ev_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next expected event.
  always @(negedge Clk) begin : mon
    ev_t e;
    if (reset && (kif.key_press != 4'b0000 || kif.key_release != 4'b0000)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got press=%b release=%b want none (cyc %0d)",
                 kif.key_press, kif.key_release, cyc);
      end else begin
        e = sb.pop_front();
        $display("event cyc=%0d press=%b release=%b level=%b", cyc, kif.key_press,
                 kif.key_release, kif.key_level);
        check_int("strobe_cycle", cyc, e.at);
        check("strobe_press", kif.key_press, e.press);
        check("strobe_release", kif.key_release, e.rel);
        check("strobe_level", kif.key_level, e.level);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int dly, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l);
    ev_t e;
    e.at    = cyc + dly;
    e.press = p;
    e.rel   = r;
    e.level = l;
    sb.push_back(e);
  endtask

  task automatic check_out(input string name, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r);
    @(negedge Clk);
    check({name, "_level"}, kif.key_level, l);
    check({name, "_press"}, kif.key_press, p);
    check({name, "_release"}, kif.key_release, r);
  endtask

  initial begin
    kif.key_n = 4'b0000;
    reset = 1'b0;

    // 1: outputs quiet in reset, then all four held keys accepted together.
    repeat (3) check_out("t1_in_reset", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    reset = 1'b1;
    expect_ev(10, 4'b1111, 4'b0000, 4'b1111);
    tick(9);
    check_out("t1_edge9", 4'b0000, 4'b0000, 4'b0000);
    tick(5);
    check_out("t1_held", 4'b1111, 4'b0000, 4'b0000);
    tick(1);
    kif.key_n = 4'b1111;
    expect_ev(10, 4'b0000, 4'b1111, 4'b0000);
    tick(14);
    check_out("t1_released", 4'b0000, 4'b0000, 4'b0000);

    // 2: clean press of key 0, strobe on edge 10 only.
    tick(1);
    kif.key_n = 4'b1110;
    expect_ev(10, 4'b0001, 4'b0000, 4'b0001);
    tick(9);
    check_out("t2_edge9", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("t2_edge10", 4'b0001, 4'b0001, 4'b0000);
    tick(1);
    check_out("t2_edge11", 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    kif.key_n = 4'b1111;
    expect_ev(10, 4'b0000, 4'b0001, 4'b0000);
    tick(14);

    // 3: key 1 bounces in 3-cycle segments before settling low.
    tick(1);
    kif.key_n = 4'b1101;
    tick(3);
    kif.key_n = 4'b1111;
    tick(3);
    kif.key_n = 4'b1101;
    tick(3);
    kif.key_n = 4'b1111;
    tick(3);
    kif.key_n = 4'b1101;
    expect_ev(10, 4'b0010, 4'b0000, 4'b0010);
    tick(14);
    check_out("t3_held", 4'b0010, 4'b0000, 4'b0000);
    tick(1);
    kif.key_n = 4'b1111;
    expect_ev(10, 4'b0000, 4'b0010, 4'b0000);
    tick(14);

    // 4: key 2 held for 50 cycles; level high exactly 50 cycles.
    tick(1);
    kif.key_n = 4'b1011;
    expect_ev(10, 4'b0100, 4'b0000, 4'b0100);
    tick(50);
    kif.key_n = 4'b1111;
    expect_ev(10, 4'b0000, 4'b0100, 4'b0000);
    tick(14);
    check_out("t4_released", 4'b0000, 4'b0000, 4'b0000);

    // 5: key 0 accepted, then reset hits while key 3 is mid-count.
    tick(1);
    kif.key_n = 4'b1110;
    expect_ev(10, 4'b0001, 4'b0000, 4'b0001);
    tick(14);
    check_out("t5_pre", 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    kif.key_n = 4'b0110;
    tick(7);
    reset = 1'b0;
    #1;
    check("t5_async_level", kif.key_level, 4'b0000);
    check("t5_async_press", kif.key_press, 4'b0000);
    check("t5_async_release", kif.key_release, 4'b0000);
    tick(1);
    reset = 1'b1;
    expect_ev(10, 4'b1001, 4'b0000, 4'b1001);
    tick(9);
    check_out("t5_edge9", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("t5_edge10", 4'b1001, 4'b1001, 4'b0000);
    tick(1);
    kif.key_n = 4'b1111;
    expect_ev(10, 4'b0000, 4'b1001, 4'b0000);
    tick(14);

    // 6: keys 0 and 3 together, key 1 glitches low for 7 cycles.
    tick(1);
    kif.key_n = 4'b0100;
    expect_ev(10, 4'b1001, 4'b0000, 4'b1001);
    tick(7);
    kif.key_n = 4'b0110;
    tick(7);
    check_out("t6_after", 4'b1001, 4'b0000, 4'b0000);
    tick(10);
    check_out("t6_late", 4'b1001, 4'b0000, 4'b0000);
    tick(1);
    kif.key_n = 4'b1111;
    expect_ev(10, 4'b0000, 4'b1001, 4'b0000);
    tick(14);

    // Every expected strobe must have been seen.
    check_int("pending_events", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
